sipo_deserializer: RTL

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: framed bits are assembled into a WIDTH-bit word
// held for a downstream consumer, with frame-error and overrun reporting.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Serial_In,
  input  logic             Bit_Valid,
  input  logic             Frame_Start,
  input  logic             Word_Ack,
  input  logic             Overrun_Clr,
  output logic [WIDTH-1:0] Data_Output,
  output logic             Word_Valid,
  output logic             Busy,
  output logic             Frame_Error,
  output logic             Overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;

  logic             start_bit;
  logic             shift_bit;
  logic             complete;
  logic             load_word;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] shifted_word;

  assign start_bit = Bit_Valid && Frame_Start;
  assign shift_bit = (state == SHIFT) && Bit_Valid && !Frame_Start;
  assign count_inc = count + CW'(1);
  assign complete  = shift_bit && (count_inc == CW'(WIDTH));
  assign load_word = complete && (!Word_Valid || Word_Ack);

  // The bit order decides which end of the register the first bit enters from.
  always_comb begin
    first_word   = '0;
    shifted_word = '0;
    if (MSB_FIRST) begin
      first_word[0] = Serial_In;
      shifted_word  = {shreg[WIDTH-2:0], Serial_In};
    end else begin
      first_word[WIDTH-1] = Serial_In;
      shifted_word        = {Serial_In, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      count       <= '0;
      Frame_Error <= 1'b0;
    end else begin
      Frame_Error <= (state == SHIFT) && start_bit;
      if (start_bit) begin
        state <= SHIFT;
        shreg <= first_word;
        count <= CW'(1);
      end else if (shift_bit) begin
        shreg <= shifted_word;
        if (complete) begin
          state <= IDLE;
          count <= '0;
        end else begin
          count <= count_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Data_Output <= '0;
      Word_Valid  <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      if (load_word) begin
        Data_Output <= shifted_word;
        Word_Valid  <= 1'b1;
      end else if (Word_Valid && Word_Ack) begin
        Word_Valid <= 1'b0;
      end
      // A completed word that finds the holding register occupied is dropped; set beats clear.
      if (complete && Word_Valid && !Word_Ack)
        Overrun <= 1'b1;
      else if (Overrun_Clr)
        Overrun <= 1'b0;
    end
  end

  assign Busy = (state == SHIFT);

endmodule
